switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the number of consecutive sampled edges a new input level must hold before acceptance; legal range 2..65535.
REQ-002 Parameter CNT_W, default $clog2(DEBOUNCE_CYCLES+1), SHALL set the counter width; it is not overridden by instantiators.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 A_RAW  input  1  SHALL be the unsynchronised, bouncing switch level for channel A.
REQ-006 B_RAW  input  1  SHALL be the unsynchronised, bouncing switch level for channel B.
REQ-007 A  output  1  SHALL be the clean debounced level of channel A, which drives the downstream two-input gate's A input.
REQ-008 B  output  1  SHALL be the clean debounced level of channel B, which drives the downstream gate's B input.
REQ-009 A_RISE, A_FALL, B_RISE, B_FALL  output  1 each  SHALL exist only when SWITCH_DEBOUNCE_EDGE_EN is defined (see REQ-024).

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchroniser before any other logic; no raw input reaches combinational logic.
REQ-011 Each channel SHALL run an independent FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-012 From STABLE_LO, a synced value of 1 SHALL move the FSM to WAIT_HI with the counter loaded to 1. From STABLE_HI, a synced value of 0 SHALL move it to WAIT_LO with the counter loaded to 1.
REQ-013 In a WAIT state, each edge on which the synced value still differs from the output SHALL increment the counter.
REQ-014 When the counter reaches DEBOUNCE_CYCLES, the FSM SHALL enter the opposite STABLE state and the output SHALL take the new level on that same edge.
REQ-015 In a WAIT state, any edge on which the synced value equals the current output SHALL return the FSM to the originating STABLE state, clear the counter, and leave the output unchanged (glitch rejection).
REQ-016 Latency: if edge N is the first edge sampling a steady new raw level, the output SHALL change on edge N+1+DEBOUNCE_CYCLES; a pulse shorter than DEBOUNCE_CYCLES synced cycles SHALL never reach the output.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES and SHALL hold 0 in STABLE states.
REQ-018 Channels A and B SHALL be fully independent; simultaneous transitions on both SHALL update both outputs on the same edge, with no priority.
REQ-019 Outputs A and B SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-020 RST_N low SHALL immediately, without waiting for CLK, clear the synchronisers, counters and outputs (A=0, B=0, all edge pulses 0) and force both FSMs to STABLE_LO.
REQ-021 Reset asserted mid-WAIT SHALL discard the pending transition; after release, the debounce window restarts from zero.
REQ-022 After RST_N deassertion, a raw input already high SHALL appear on the output after exactly the REQ-016 latency.

Configuration
REQ-023 Macro SWITCH_DEBOUNCE_EDGE_EN SHALL control the edge-pulse feature.
REQ-024 With the macro defined, the x_RISE/x_FALL outputs SHALL exist as registered one-cycle pulses, asserted on the same edge the matching output rises or falls.
REQ-025 Without the macro, the x_RISE/x_FALL ports and their flops SHALL be absent, and level behaviour SHALL be identical.

Structure
REQ-026 A shared package gates_pkg SHALL hold the 2-bit FSM state typedef (STABLE_LO=0, WAIT_HI=1, STABLE_HI=2, WAIT_LO=3) and the DEBOUNCE_CYCLES_DEFAULT constant (16).
REQ-027 Per-channel logic (synchroniser, FSM, counter, edge flops) SHALL live in sub-module debounce_channel, instantiated twice by switch_debounce.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset: RST_N low mid-cycle with A_RAW=B_RAW=1 -> A=B=0 before the next CLK edge; both FSMs in STABLE_LO.
REQ-029 Clean rise: A_RAW 0->1 first sampled at edge 10 and held -> A=1 after edge 15, A_RISE high only during the cycle after edge 15 (macro on).
REQ-030 Glitch: B_RAW high for 2 cycles, then low -> B stays 0 throughout; FSM returns to STABLE_LO, counter=0.
REQ-031 Bounce: A_RAW toggles 1,0,1,0,1, then holds 1 from edge 20 -> A rises exactly once, after edge 25; exactly one A_RISE pulse.
REQ-032 Simultaneous: A_RAW and B_RAW both 1->0 first sampled at edge 40 -> A and B fall together after edge 45; A_FALL and B_FALL pulse on the same cycle.
REQ-033 Reset mid-WAIT: A_RAW held high and RST_N pulsed low at edge 13, released before edge 14 -> A=0 and A_RISE=0 until after edge 19 (window restarts).

Source files
------------

// File: rtl/gates_pkg.sv
// -----------------------------------------------------------------------------
// gates_pkg
// Shared definitions for the switch debouncer:
//   - deb_state_e            : 2-bit per-channel debounce FSM state
//   - DEBOUNCE_CYCLES_DEFAULT: default number of sampled edges a new level
//                              must hold before it is accepted
// -----------------------------------------------------------------------------
package gates_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_e;

endpackage : gates_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounced switch channel: 2-flop synchroniser, 4-state debounce FSM
// with a consecutive-sample counter, and a registered clean level.
// Optional macro SWITCH_DEBOUNCE_EDGE_EN adds registered one-cycle rise/fall
// pulses aligned with the level change.
//
// Ports:
//   clk_i   : clock, rising-edge
//   rst_ni  : asynchronous active-low reset
//   raw_i   : unsynchronised bouncing switch level
//   level_o : clean debounced level (flop output)
//   rise_o  : one-cycle pulse when level_o rises   (SWITCH_DEBOUNCE_EDGE_EN)
//   fall_o  : one-cycle pulse when level_o falls   (SWITCH_DEBOUNCE_EDGE_EN)
// -----------------------------------------------------------------------------
module debounce_channel
    import gates_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q;
    logic             level_d;

    // Two-flop synchroniser; nothing downstream ever sees raw_i directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign cnt_inc = cnt_q + CNT_ONE;

    // Debounce FSM next-state, counter and level logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            STABLE_LO: begin
                if (sync2_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_HI: begin
                if (sync2_q) begin
                    // Accept on the edge where the count would hit the target,
                    // so the counter never holds DEBOUNCE_CYCLES itself.
                    if (cnt_inc == CNT_TARGET) begin
                        state_d = STABLE_HI;
                        cnt_d   = CNT_ZERO;
                        level_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = STABLE_LO;
                    cnt_d   = CNT_ZERO;
                end
            end
            STABLE_HI: begin
                if (!sync2_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_LO: begin
                if (!sync2_q) begin
                    if (cnt_inc == CNT_TARGET) begin
                        state_d = STABLE_LO;
                        cnt_d   = CNT_ZERO;
                        level_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = STABLE_HI;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM state, counter and clean level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= STABLE_LO;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Edge pulses registered on the same edge the level flop changes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= level_d & ~level_q;
            fall_q <= ~level_d & level_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

endmodule : debounce_channel

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
// Two independent debounced switch channels (A and B) feeding a downstream
// two-input gate. Each channel is a debounce_channel instance.
// Optional macro SWITCH_DEBOUNCE_EDGE_EN adds the A/B rise/fall pulse ports.
//
// Ports:
//   CLK            : clock, rising-edge
//   RST_N          : asynchronous active-low reset
//   A_RAW, B_RAW   : raw bouncing switch levels
//   A, B           : clean debounced levels (flop outputs)
//   A_RISE, A_FALL,
//   B_RISE, B_FALL : one-cycle edge pulses (SWITCH_DEBOUNCE_EDGE_EN only)
// -----------------------------------------------------------------------------
module switch_debounce
    import gates_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic A_RAW,
    input  logic B_RAW,
    output logic A,
    output logic B
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic A_RISE,
    output logic A_FALL,
    output logic B_RISE,
    output logic B_FALL
`endif
);

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_a (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .raw_i   (A_RAW),
        .level_o (A)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        ,
        .rise_o  (A_RISE),
        .fall_o  (A_FALL)
`endif
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_b (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .raw_i   (B_RAW),
        .level_o (B)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        ,
        .rise_o  (B_RISE),
        .fall_o  (B_FALL)
`endif
    );

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
// Scoreboard bench for switch_debounce with DEBOUNCE_CYCLES = 4.
// The reference model keeps the full history of raw samples since reset and
// declares a level change when the last D synchronised samples all carry the
// new level (synchronised sample at edge k = raw sampled at edge k-2).
// -----------------------------------------------------------------------------
module tb_switch_debounce;

    localparam int D = 4;

    logic clk;
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic a_o;
    logic b_o;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic a;
        logic b;
        logic ar;
        logic af;
        logic br;
        logic bf;
    } exp_t;

    exp_t exp_q[$];
    logic hist_a[$];
    logic hist_b[$];
    logic exp_a;
    logic exp_b;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    switch_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .A_RAW  (a_raw),
        .B_RAW  (b_raw),
        .A      (a_o),
        .B      (b_o),
        .A_RISE (a_rise),
        .A_FALL (a_fall),
        .B_RISE (b_rise),
        .B_FALL (b_fall)
    );
`else
    switch_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .A_RAW  (a_raw),
        .B_RAW  (b_raw),
        .A      (a_o),
        .B      (b_o)
    );
    assign a_rise = 1'b0;
    assign a_fall = 1'b0;
    assign b_rise = 1'b0;
    assign b_fall = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Synchronised value seen by the FSM at edge index idx (0 = first edge after reset).
    function automatic logic synced_of(input int ch, input int idx);
        if (idx < 2) return 1'b0;
        return (ch == 0) ? hist_a[idx-2] : hist_b[idx-2];
    endfunction

    // True when the last D synchronised samples all equal v.
    function automatic logic window_all(input int ch, input logic v);
        int n;
        n = (ch == 0) ? hist_a.size() : hist_b.size();
        if (n < D) return 1'b0;
        for (int j = 0; j < D; j++) begin
            if (synced_of(ch, n - 1 - j) !== v) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_step(input logic a, input logic b);
        exp_t e;
        logic na;
        logic nb;
        hist_a.push_back(a);
        hist_b.push_back(b);
        na = window_all(0, ~exp_a) ? ~exp_a : exp_a;
        nb = window_all(1, ~exp_b) ? ~exp_b : exp_b;
        e.a  = na;
        e.b  = nb;
        e.ar = na & ~exp_a;
        e.af = ~na & exp_a;
        e.br = nb & ~exp_b;
        e.bf = ~nb & exp_b;
        exp_a = na;
        exp_b = nb;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        hist_a.delete();
        hist_b.delete();
        exp_q.delete();
        exp_a = 1'b0;
        exp_b = 1'b0;
    endfunction

    // One clock: apply raw levels, let the edge sample them, log the expectation.
    task automatic step(input logic a, input logic b);
        a_raw = a;
        b_raw = b;
        @(posedge clk);
        model_step(a, b);
        #1;
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) step(a, b);
    endtask

    // Mid-cycle reset pulse; outputs must clear before the next edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_a", a_o, 1'b0);
        chk("async_rst_b", b_o, 1'b0);
        chk("async_rst_ar", a_rise, 1'b0);
        chk("async_rst_bf", b_fall, 1'b0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compare every registered output against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("level_a", a_o, e.a);
            chk("level_b", b_o, e.b);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            chk("rise_a", a_rise, e.ar);
            chk("fall_a", a_fall, e.af);
            chk("rise_b", b_rise, e.br);
            chk("fall_b", b_fall, e.bf);
`endif
        end
    end

    initial begin
        logic ra;
        logic rb;
        rst_n = 1'b0;
        a_raw = 1'b1;
        b_raw = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", a_o, 1'b0);
        chk("reset_b", b_o, 1'b0);
        #2 rst_n = 1'b1;

        // Raw already high at release: output changes on the (D+2)-th edge.
        for (int k = 1; k <= D + 2; k++) begin
            step(1'b1, 1'b1);
            chk("latency_a", a_o, (k == D + 2) ? 1'b1 : 1'b0);
            chk("latency_b", b_o, (k == D + 2) ? 1'b1 : 1'b0);
        end
        hold(1'b1, 1'b1, 3);

        // Reset with both outputs high.
        do_reset();

        // Reset in the middle of a WAIT window: window restarts.
        hold(1'b1, 1'b1, 4);
        do_reset();
        for (int k = 1; k <= D + 2; k++) begin
            step(1'b1, 1'b0);
            chk("restart_a", a_o, (k == D + 2) ? 1'b1 : 1'b0);
        end

        // Short pulse on B is rejected.
        hold(1'b1, 1'b0, 6);
        hold(1'b1, 1'b1, 2);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            chk("glitch_b", b_o, 1'b0);
        end

        // Bounce on A falling then rising.
        hold(1'b0, 1'b0, 10);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        hold(1'b1, 1'b0, 10);

        // Simultaneous rise then fall on both channels.
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b0, 10);

        // Randomised bouncing with occasional resets.
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) < 2) ra = ~ra;
            if ($urandom_range(0, 9) < 2) rb = ~rb;
            if ($urandom_range(0, 49) == 0) begin
                ra = 1'b1;
                rb = 1'b1;
            end
            step(ra, rb);
            if ((i % 200) == 150) do_reset();
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_switch_debounce
